// File: rtl/biaojue_vote.sv
// Five-input majority voter: registers the verdict, the yes count and a unanimity flag,
// and keeps saturating pass/reject tallies.
module biaojue_vote #(
   parameter int CNT_W = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             vote_en,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             e,
   output logic             result,
   output logic [2:0]       vote_cnt,
   output logic             unanimous,
   output logic             valid,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2:0] yes;
   logic       pass;

   // Five one-bit ballots sum to at most 5, so three bits never overflow.
   always_comb begin
      yes  = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d} + {2'b00, e};
      pass = (yes >= 3'd3);
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         result    <= 1'b0;
         vote_cnt  <= 3'd0;
         unanimous <= 1'b0;
         valid     <= 1'b0;
         pass_cnt  <= '0;
         fail_cnt  <= '0;
      end else if (vote_en) begin
         result    <= pass;
         vote_cnt  <= yes;
         unanimous <= (yes == 3'd0) || (yes == 3'd5);
         valid     <= 1'b1;
         if (pass) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
         end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
         end
      end else begin
         valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_biaojue_vote.sv
// Self-checking bench for biaojue_vote: directed cases plus randomized ballots
// compared against a counting model; a 3-bit-counter instance covers saturation.
module tb_biaojue_vote;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        vote_en;
   logic        a, b, c, d, e;

   logic        result, result_s;
   logic [2:0]  vote_cnt, vote_cnt_s;
   logic        unanimous, unanimous_s;
   logic        valid, valid_s;
   logic [15:0] pass_cnt, fail_cnt;
   logic [2:0]  pass_cnt_s, fail_cnt_s;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_result, m_cnt, m_unan, m_valid, m_pass, m_fail;
   int en_count;

   biaojue_vote #(.CNT_W(16)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .vote_en(vote_en),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .result(result), .vote_cnt(vote_cnt), .unanimous(unanimous), .valid(valid),
      .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
   );

   biaojue_vote #(.CNT_W(3)) dut_s (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .vote_en(vote_en),
      .a(a), .b(b), .c(c), .d(d), .e(e),
      .result(result_s), .vote_cnt(vote_cnt_s), .unanimous(unanimous_s), .valid(valid_s),
      .pass_cnt(pass_cnt_s), .fail_cnt(fail_cnt_s)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic compare_all(input string tag);
      check({tag, ".result"},      int'(result),      m_result);
      check({tag, ".vote_cnt"},    int'(vote_cnt),    m_cnt);
      check({tag, ".unanimous"},   int'(unanimous),   m_unan);
      check({tag, ".valid"},       int'(valid),       m_valid);
      check({tag, ".pass_cnt"},    int'(pass_cnt),    sat(m_pass, 16));
      check({tag, ".fail_cnt"},    int'(fail_cnt),    sat(m_fail, 16));
      check({tag, ".s.result"},    int'(result_s),    m_result);
      check({tag, ".s.vote_cnt"},  int'(vote_cnt_s),  m_cnt);
      check({tag, ".s.valid"},     int'(valid_s),     m_valid);
      check({tag, ".s.pass_cnt"},  int'(pass_cnt_s),  sat(m_pass, 3));
      check({tag, ".s.fail_cnt"},  int'(fail_cnt_s),  sat(m_fail, 3));
   endtask

   // One clock: drive at negedge, update model at posedge, sample 1 ns later.
   task automatic step(input string tag, input logic rst, input logic en, input logic [4:0] bal);
      int yes;
      @(negedge sys_clk);
      sys_rst = rst;
      vote_en = en;
      {a, b, c, d, e} = bal;
      @(posedge sys_clk);
      yes = $countones(bal);
      if (rst) begin
         m_result = 0; m_cnt = 0; m_unan = 0; m_valid = 0;
         m_pass = 0; m_fail = 0; en_count = 0;
      end else if (en) begin
         m_result = (yes >= 3) ? 1 : 0;
         m_cnt    = yes;
         m_unan   = (yes == 0 || yes == 5) ? 1 : 0;
         m_valid  = 1;
         if (yes >= 3) m_pass++; else m_fail++;
         en_count++;
      end else begin
         m_valid = 0;
      end
      #1;
      compare_all(tag);
   endtask

   initial begin
      sys_rst = 1'b1; vote_en = 1'b0; {a, b, c, d, e} = 5'b0;

      // Reset held two cycles while a unanimous yes vote is offered.
      step("rst0", 1'b1, 1'b1, 5'b11111);
      step("rst1", 1'b1, 1'b1, 5'b11111);
      check("rst.pass_cnt_zero", int'(pass_cnt), 0);

      // All 32 ballot patterns, one per cycle.
      for (int p = 0; p < 32; p++) begin
         step("exh", 1'b0, 1'b1, 5'(p));
         if (p == 5'b00111) check("exh.00111.result", int'(result), 1);
         if (p == 5'b00011) check("exh.00011.result", int'(result), 0);
      end
      check("exh.pass_total", int'(pass_cnt), 16);
      check("exh.fail_total", int'(fail_cnt), 16);

      // Enable gating: one vote, then five disabled cycles with changed ballots.
      step("gate.rst", 1'b1, 1'b0, 5'b00000);
      step("gate.vote", 1'b0, 1'b1, 5'b11100);
      for (int i = 0; i < 5; i++) begin
         step("gate.hold", 1'b0, 1'b0, 5'b00000);
         check("gate.result", int'(result), 1);
         check("gate.vote_cnt", int'(vote_cnt), 3);
         check("gate.valid_low", int'(valid), 0);
      end
      check("gate.pass_cnt", int'(pass_cnt), 1);

      // Saturation on the 3-bit instance.
      step("sat.rst", 1'b1, 1'b0, 5'b00000);
      for (int i = 0; i < 10; i++) step("sat", 1'b0, 1'b1, 5'b11111);
      check("sat.pass_cnt_s", int'(pass_cnt_s), 7);
      check("sat.fail_cnt_s", int'(fail_cnt_s), 0);
      check("sat.pass_cnt_wide", int'(pass_cnt), 10);

      // Reset collides with a vote after counters are nonzero.
      step("coll.rst", 1'b1, 1'b1, 5'b11111);
      check("coll.pass_cnt", int'(pass_cnt), 0);
      check("coll.result", int'(result), 0);
      step("coll.vote", 1'b0, 1'b1, 5'b11000);
      check("coll.fail_cnt", int'(fail_cnt), 1);
      check("coll.result0", int'(result), 0);

      // Randomized ballots and enables.
      step("rnd.rst", 1'b1, 1'b0, 5'b00000);
      for (int i = 0; i < 1000; i++)
         step("rnd", 1'b0, 1'($urandom_range(0, 1)), 5'($urandom));
      check("rnd.total", int'(pass_cnt) + int'(fail_cnt), en_count);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/biaojue_vote.md
# biaojue_vote

Five-input majority voter ("biaojue") for the EDA lab designs. Each enabled clock samples five one-bit ballots `a`..`e`. It registers a pass/fail verdict (pass = at least three of five are 1), the yes-vote count, a unanimity flag and running pass/reject tallies. It sits between the ballot inputs (switches or debounced keys) and the display/LED logic.

## Interface
Parameters:
- `CNT_W`, default 16: width of the pass and reject tally counters.

Ports:
- `sys_clk`, in, 1: single system clock; all state updates on its rising edge.
- `sys_rst`, in, 1: synchronous, active-high reset, sampled on the `sys_clk` rising edge.
- `vote_en`, in, 1: ballot sample strobe; ballots are counted only in cycles where it is 1.
- `a`, `b`, `c`, `d`, `e`, in, 1 each: ballots; 1 = yes, 0 = no.
- `result`, out, 1: registered verdict; 1 when the yes count ≥ 3.
- `vote_cnt`, out, 3: registered yes count, range 0..5.
- `unanimous`, out, 1: registered; 1 when the yes count is 0 or 5.
- `valid`, out, 1: one-cycle pulse marking freshly updated verdict outputs.
- `pass_cnt`, out, CNT_W: number of passed votes since reset, saturating.
- `fail_cnt`, out, CNT_W: number of rejected votes since reset, saturating.

## Operation
- Combinational popcount: `yes = a+b+c+d+e`, computed at 3-bit width with no overflow possible.
- `pass = (yes >= 3)`. This is equivalent to the sum of products over all 3-of-5 combinations. Either form is acceptable if it is functionally identical for all 32 input patterns.
- On a rising edge with `sys_rst`=1, all outputs and counters are cleared to 0: `result`=0, `vote_cnt`=0, `unanimous`=0, `valid`=0, `pass_cnt`=0, `fail_cnt`=0.
- On a rising edge with `sys_rst`=0 and `vote_en`=1:
  - `result` ← `pass`
  - `vote_cnt` ← `yes`
  - `unanimous` ← (`yes`==0 or `yes`==5)
  - `valid` ← 1
  - if `pass`, `pass_cnt` increments, otherwise `fail_cnt` increments.
- On a rising edge with `sys_rst`=0 and `vote_en`=0:
  - `result`, `vote_cnt` and `unanimous` hold their previous values.
  - `valid` ← 0.
  - Counters hold.
- Counter saturation: a counter at all-ones (2^CNT_W−1) stays there. Only the counter selected by the verdict changes in a given cycle; the other holds.
- With five voters a tie is impossible, so no tie handling is required.
- Ballot inputs are treated as synchronous to `sys_clk`. Synchronizing external asynchronous sources is outside this block.
- Reset has priority over `vote_en`.

## Timing
- Latency is one cycle. Ballots sampled at edge N appear on `result`, `vote_cnt`, `unanimous`, `valid` and the counters immediately after edge N.
- Throughput is one vote per clock. Back-to-back `vote_en` cycles are all counted, and `valid` then stays high continuously.
- A reset asserted in the same cycle as `vote_en`=1 discards that vote: all outputs are 0 after the edge.
- If reset is asserted mid-sequence, the counters restart from 0 on the first enabled vote after reset is released.
- No combinational path from inputs to outputs; all outputs are registered.
- Ballot changes while `vote_en`=0 have no effect on any output.

## Test plan
- Reset: hold `sys_rst`=1 for 2 cycles with `a`..`e`=11111 and `vote_en`=1 → all outputs 0, and the counters stay 0.
- Exhaustive: drive all 32 patterns of `a`..`e` with `vote_en`=1 for one cycle each →
  - each next cycle shows `vote_cnt` = popcount and `result` = (popcount ≥ 3); e.g. 00111 → result=1 with cnt=3, and 00011 → result=0 with cnt=2;
  - `unanimous`=1 only for 00000 and 11111;
  - at the end `pass_cnt`=16 and `fail_cnt`=16.
- Enable gating: apply 11100 with `vote_en`=1, then 00000 with `vote_en`=0 for 5 cycles → `result` stays 1, `vote_cnt` stays 3, `valid` is high for 1 cycle only, and `pass_cnt` stays 1.
- Random: 1000 cycles of `$random` ballots with random `vote_en` → a scoreboard majority model matches every output, and `pass_cnt`+`fail_cnt` equals the number of enabled cycles.
- Saturation: with CNT_W=3, apply 10 consecutive 11111 votes → `pass_cnt` reaches 7 and holds; `fail_cnt`=0.
- Reset collision: assert `sys_rst` together with a 11111 vote after the counters are nonzero → the next cycle shows all outputs 0, and the following enabled 11000 vote gives `fail_cnt`=1 with `result`=0.
